// File: rtl/conv3x3_layer_ctrl.sv
// conv3x3_layer_ctrl: frame sequencer for the kernelWindow -> conv_3x3 datapath.
// Ports: start/busy/done/err control; cfg_* config stream (9 weights + bias);
//   s_* pixel stream in; win_* to kernelWindow; weights_o/bias_o to conv_3x3;
//   conv_valid back from conv_3x3; out_count results seen this frame.
module conv3x3_layer_ctrl #(
    parameter int WIDTH   = 10,
    parameter int HEIGHT  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        cfg_valid,
    input  logic [31:0] cfg_data,
    output logic        cfg_ready,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        win_flush,
    output logic [7:0]  win_pixel,
    output logic        win_valid,
    output logic [71:0] weights_o,
    output logic [31:0] bias_o,
    input  logic        conv_valid,
    output logic [15:0] out_count
);

    localparam logic [15:0] LAST_PIX = 16'(WIDTH * HEIGHT - 1);
    localparam logic [15:0] TARGET   = 16'((WIDTH - 2) * (HEIGHT - 2));
    localparam int          IW       = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        STREAM,
        DRAIN
    } state_t;

    state_t        state;
    logic [3:0]    cfg_cnt;
    logic [15:0]   pix_cnt;
    logic [IW-1:0] idle_cnt;

    logic          counting;
    logic [15:0]   count_next;
    logic          cnt_hit;

    // The count never passes TARGET; cnt_hit covers both the reaching
    // increment and an already-saturated count so DRAIN always exits.
    always_comb begin
        counting   = 1'b0;
        count_next = out_count;
        cnt_hit    = 1'b0;
        if ((state == STREAM || state == DRAIN) && conv_valid
            && out_count != TARGET) begin
            counting = 1'b1;
        end
        count_next = out_count + {15'b0, counting};
        cnt_hit    = (count_next == TARGET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cfg_ready <= 1'b0;
            s_ready   <= 1'b0;
            win_flush <= 1'b0;
            win_pixel <= 8'd0;
            win_valid <= 1'b0;
            weights_o <= 72'd0;
            bias_o    <= 32'd0;
            out_count <= 16'd0;
            cfg_cnt   <= 4'd0;
            pix_cnt   <= 16'd0;
            idle_cnt  <= '0;
        end else begin
            done      <= 1'b0;
            win_flush <= 1'b0;
            win_valid <= 1'b0;
            if (counting) begin
                out_count <= count_next;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b1;
                        err       <= 1'b0;
                        out_count <= 16'd0;
                        cfg_cnt   <= 4'd0;
                        pix_cnt   <= 16'd0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        for (int k = 0; k < 9; k++) begin
                            if (cfg_cnt == 4'(k)) begin
                                weights_o[8*k +: 8] <= cfg_data[7:0];
                            end
                        end
                        if (cfg_cnt == 4'd9) begin
                            bias_o    <= cfg_data;
                            cfg_ready <= 1'b0;
                            win_flush <= 1'b1;
                            state     <= FLUSH;
                        end else begin
                            cfg_cnt <= cfg_cnt + 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    state   <= STREAM;
                    s_ready <= 1'b1;
                end
                STREAM: begin
                    // s_ready is always high here, so s_valid alone accepts.
                    if (s_valid) begin
                        win_valid <= 1'b1;
                        win_pixel <= s_data;
                        if (pix_cnt == LAST_PIX) begin
                            s_ready  <= 1'b0;
                            idle_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            pix_cnt <= pix_cnt + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_hit) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (conv_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_layer_ctrl.sv
// tb_conv3x3_layer_ctrl: randomized directed bench for conv3x3_layer_ctrl.
// Ports: none; drives config/pixel/conv streams and checks against a frame model.
module tb_conv3x3_layer_ctrl;

    localparam int W    = 10;
    localparam int H    = 10;
    localparam int TO   = 64;
    localparam int NPIX = W * H;
    localparam int TGT  = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_data = 32'd0;
    logic        cfg_ready;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        win_flush;
    logic [7:0]  win_pixel;
    logic        win_valid;
    logic [71:0] weights_o;
    logic [31:0] bias_o;
    logic        conv_valid = 1'b0;
    logic [15:0] out_count;

    int checks = 0;
    int errors = 0;
    int nwv, ndone, nflush;

    conv3x3_layer_ctrl #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .win_flush(win_flush), .win_pixel(win_pixel),
        .win_valid(win_valid), .weights_o(weights_o), .bias_o(bias_o),
        .conv_valid(conv_valid), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally output events.
    task automatic cyc();
        @(negedge clk);
        if (win_valid) nwv++;
        if (done) ndone++;
        if (win_flush) nflush++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 128'({busy, done, err, cfg_ready, s_ready,
            win_flush, win_pixel, win_valid, out_count}), 128'd0);
        chk({tag, "_wb"}, 128'({weights_o, bias_o}), 128'd0);
    endtask

    // mode 0: normal conv results, 1: no conv results (timeout),
    // 2: conv_valid kept high after the frame ends.
    task automatic run_frame(input logic [71:0] wpk, input logic [31:0] b,
                             input bit ones, input bit cfg_alt,
                             input int pix_pct, input int mode,
                             input int abort_at, input bit start_mid);
        logic [7:0] px[$];
        int  wi, pi, pend, sent, cnt, exp_cnt;
        bit  acc;
        nwv = 0; ndone = 0; nflush = 0;
        px.delete();
        for (int i = 0; i < NPIX; i++)
            px.push_back(ones ? 8'd1 : 8'($urandom()));
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'd1);
        chk("start_err_clr", 128'(err), 128'd0);
        chk("start_cnt_clr", 128'(out_count), 128'd0);
        chk("start_cfg_ready", 128'(cfg_ready), 128'd1);

        wi = 0; cnt = 0;
        while (wi < 10 && cnt < 200) begin
            cfg_valid = cfg_alt ? cnt[0] : 1'b1;
            cfg_data  = (wi < 9) ? {24'($urandom()), wpk[8*wi +: 8]} : b;
            if (cfg_valid && cfg_ready) wi++;
            cyc();
            cnt++;
        end
        cfg_valid = 1'b0;
        chk("load_words", 128'(wi), 128'd10);
        chk("load_weights", 128'(weights_o), 128'(wpk));
        chk("load_bias", 128'(bias_o), 128'(b));
        chk("load_ready_drop", 128'(cfg_ready), 128'd0);
        chk("flush_pulse", 128'(win_flush), 128'd1);

        pi = 0; pend = 0; sent = 0; cnt = 0;
        while (pi < NPIX && cnt < 2000) begin
            if (abort_at != 0 && pi == abort_at) break;
            start = (start_mid && pi == 50);
            conv_valid = (mode != 1 && pend > 0 && $urandom_range(1) == 1);
            if (conv_valid) begin pend--; sent++; end
            s_valid = ($urandom_range(99) < pix_pct);
            s_data  = s_valid ? px[pi] : 8'($urandom());
            acc = s_valid && s_ready;
            if (acc) begin
                if (pi / W >= 2 && pi % W >= 2) pend++;
                pi++;
            end
            cyc();
            cnt++;
            chk("win_valid", 128'(win_valid), 128'(acc));
            if (acc) chk("win_pixel", 128'(win_pixel), 128'(px[pi-1]));
        end
        s_valid = 1'b0;
        start = 1'b0;

        if (abort_at != 0) begin
            conv_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk_zero("abort");
            cyc();
            rst_n = 1'b1;
            cyc();
        end else begin
            chk("pix_count", 128'(pi), 128'(NPIX));
            chk("s_ready_after_last", 128'(s_ready), 128'd0);
            chk("w_stable_stream", 128'(weights_o), 128'(wpk));
            cnt = 0;
            while (!done && cnt < 500) begin
                if (mode == 1) conv_valid = 1'b0;
                else if (pend > 0) begin
                    conv_valid = ($urandom_range(1) == 1);
                    if (conv_valid) begin pend--; sent++; end
                end else conv_valid = 1'b0;
                cyc();
                cnt++;
            end
            if (mode == 1) chk("timeout_cycles", 128'(cnt), 128'(TO));
            chk("done_seen", 128'(done), 128'd1);
            chk("busy_at_done", 128'(busy), 128'd0);
            conv_valid = (mode == 2);
            cyc();
            chk("done_one_cycle", 128'(done), 128'd0);
            cyc();
            cyc();
            conv_valid = 1'b0;
            cyc();
            exp_cnt = (mode == 1) ? 0 : ((sent > TGT) ? TGT : sent);
            chk("out_count", 128'(out_count), 128'(exp_cnt));
            chk("err_flag", 128'(err), 128'(mode == 1));
            chk("done_count", 128'(ndone), 128'd1);
            chk("flush_count", 128'(nflush), 128'd1);
            chk("win_valid_count", 128'(nwv), 128'(NPIX));
            chk("w_hold", 128'(weights_o), 128'(wpk));
            chk("b_hold", 128'(bias_o), 128'(b));
        end
    endtask

    logic [71:0] wr;
    logic [71:0] wseq;

    initial begin
        repeat (3) cyc();
        chk_zero("reset");
        rst_n = 1'b1;
        cyc();

        run_frame({9{8'd1}}, 32'd5, 1'b1, 1'b0, 100, 0, 0, 1'b0);

        wr = {8'($urandom()), $urandom(), $urandom()};
        run_frame(wr, $urandom(), 1'b0, 1'b1, 50, 0, 0, 1'b0);

        wr = {8'($urandom()), $urandom(), $urandom()};
        run_frame(wr, $urandom(), 1'b0, 1'b0, 80, 2, 0, 1'b1);

        wr = {8'($urandom()), $urandom(), $urandom()};
        run_frame(wr, $urandom(), 1'b0, 1'b0, 70, 1, 0, 1'b0);
        repeat (4) cyc();
        chk("err_sticky", 128'(err), 128'd1);

        wr = {8'($urandom()), $urandom(), $urandom()};
        run_frame(wr, $urandom(), 1'b0, 1'b0, 60, 0, 37, 1'b0);
        chk_zero("post_abort");
        run_frame(wr, $urandom(), 1'b0, 1'b0, 90, 0, 0, 1'b0);

        wseq = '0;
        for (int k = 0; k < 9; k++) wseq[8*k +: 8] = 8'(k + 1);
        run_frame(wseq, 32'h8000_0000, 1'b0, 1'b0, 75, 0, 0, 1'b0);
        chk("w_seq1", 128'(weights_o), 128'(72'h09_0807_0605_0403_0201));
        run_frame(wseq, 32'h8000_0000, 1'b0, 1'b1, 75, 0, 0, 1'b0);
        chk("w_seq2", 128'(weights_o), 128'(72'h09_0807_0605_0403_0201));
        chk("b_seq2", 128'(bias_o), 128'(32'h8000_0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
